// File: rtl/text_pkg.sv
// Shared types and geometry for the text-mode tile renderer.
package text_pkg;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef logic [11:0] cell_addr_t;

  localparam cell_addr_t CELLS_A   = 12'(CELLS);
  localparam cell_addr_t LAST_CELL = 12'(CELLS - 1);

  typedef struct packed {
    logic       invert;
    logic [6:0] code;
  } cell_t;

  typedef enum logic {CLEAR, RUN} state_t;

  // row*80+col without a multiplier
  function automatic cell_addr_t cell_addr(input logic [4:0] row, input logic [6:0] col);
    return ({7'b0, row} << 6) + ({7'b0, row} << 4) + {5'b0, col};
  endfunction
endpackage

// File: rtl/text_buffer_ram.sv
// Character buffer: one write port, one registered read port, read-before-write.
module text_buffer_ram
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  cell_addr_t wr_addr,
  input  cell_t      wr_data,
  input  cell_addr_t rd_addr,
  output cell_t      rd_data
);
  cell_t mem [CELLS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset so font_addr comes up as zero.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/text_tile_renderer.sv
// 80x30 text-mode pixel generator with blinking cursor; 2-cycle DrawX/DrawY -> RGB latency.
module text_tile_renderer
  import text_pkg::*;
#(
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        de,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_char,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        busy,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  state_t     state, state_nx;
  cell_addr_t clr_ptr;
  logic       ram_we;
  cell_addr_t ram_waddr;
  cell_t      ram_wdata;
  cell_t      rd_cell;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= (state == CLEAR) ? clr_ptr + 12'd1 : '0;
    end
  end

  // The clear sequencer owns the write port until the whole buffer holds spaces.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = cell_t'(wr_char);
    unique case (state)
      CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = cell_t'(SPACE_CHAR);
        if (clr_ptr == LAST_CELL) state_nx = RUN;
      end
      RUN: ram_we = wr_en && (wr_addr < CELLS_A);
    endcase
  end

  // Stage 0: address generation, cursor hit, blink tracking
  logic [6:0] col;
  logic [4:0] row;
  logic [3:0] grow;
  logic       cur_hit, frame_start, blink_phase;
  logic [BW-1:0] blink_cnt;

  assign col         = DrawX[9:3];
  assign row         = DrawY[8:4];
  assign grow        = DrawY[3:0];
  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign cur_hit     = cursor_en && blink_phase && (col == cursor_x) && (row == cursor_y)
                       && (grow[3:1] == 3'b111);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  text_buffer_ram u_ram (
    .clk     (Clk),
    .reset   (Reset),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (cell_addr(row, col)),
    .rd_data (rd_cell)
  );

  // Stage 1: carried pixel context; de is qualified by RUN so clear-time pixels stay black
  logic [3:0] grow_s1;
  logic [2:0] xb_s1;
  logic       de_s1, cur_s1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      grow_s1 <= '0;
      xb_s1   <= '0;
      de_s1   <= 1'b0;
      cur_s1  <= 1'b0;
    end else begin
      grow_s1 <= grow;
      xb_s1   <= DrawX[2:0];
      de_s1   <= de && (state == RUN);
      cur_s1  <= cur_hit;
    end
  end

  assign font_addr = {rd_cell.code, grow_s1};

  // Stage 2: registered colour
  logic        pix;
  logic [23:0] rgb;

  assign pix = (cur_s1 | font_data[3'd7 - xb_s1]) ^ rd_cell.invert;

  always_ff @(posedge Clk) begin
    if (Reset)      rgb <= '0;
    else if (de_s1) rgb <= pix ? FG_RGB : BG_RGB;
    else            rgb <= '0;
  end

  assign {red, green, blue} = rgb;
endmodule

// File: tb/tb_text_tile_renderer.sv
// Randomised + directed bench for text_tile_renderer against a cell-level reference model.
module tb_text_tile_renderer;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic [9:0]  DrawX = 10'd1, DrawY = 10'd1;
  logic        de = 1'b0, wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_char = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        busy;
  logic [7:0]  red, green, blue;

  logic [7:0] font [2048];
  assign font_data = font[font_addr];

  always #5 Clk = ~Clk;

  text_tile_renderer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .de(de),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .font_addr(font_addr), .font_data(font_data), .busy(busy),
    .red(red), .green(green), .blue(blue)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: screen memory, clear countdown, blink state, 2-deep pixel pipe
  logic [7:0]  mem [2400];
  int          clr_left = 0, bcnt = 0;
  bit          started = 0, phase = 1, fa_ok = 0, busy_b, pbit;
  int          m_col, m_row, m_gr, m_xb, m_addr;
  logic [7:0]  m_cell;
  logic [10:0] m_fa, exp_fa;
  logic [23:0] pend_rgb, exp_rgb;

  always @(posedge Clk) begin
    if (Reset) begin
      started = 1; clr_left = 2400; bcnt = 0; phase = 1;
      exp_rgb = '0; pend_rgb = '0; exp_fa = '0; fa_ok = 1;
    end else if (started) begin
      busy_b = clr_left > 0;
      m_col  = DrawX / 8;  m_xb = DrawX % 8;
      m_row  = DrawY / 16; m_gr = DrawY % 16;
      m_addr = m_row * 80 + m_col;
      m_cell = (m_addr < 2400) ? mem[m_addr] : 8'h00;
      m_fa   = {m_cell[6:0], m_gr[3:0]};
      pbit   = font[m_fa][7 - m_xb];
      if (cursor_en && phase && m_col == cursor_x && m_row == cursor_y && m_gr >= 14) pbit = 1;
      pbit    = pbit ^ m_cell[7];
      exp_rgb  = pend_rgb;
      pend_rgb = (de && !busy_b) ? (pbit ? FG : BG) : 24'h0;
      exp_fa   = m_fa;
      fa_ok    = !busy_b;
      if (!busy_b && wr_en && wr_addr < 2400) mem[wr_addr] = wr_char;
      if (DrawX == 0 && DrawY == 0) begin
        if (bcnt == 31) begin bcnt = 0; phase = !phase; end
        else bcnt++;
      end
      if (busy_b) begin
        clr_left--;
        if (clr_left == 0) foreach (mem[i]) mem[i] = 8'h20;
      end
    end
    #1;
    if (started) begin
      chk("busy", busy, clr_left > 0);
      chk("rgb", {red, green, blue}, exp_rgb);
      if (fa_ok) chk("font_addr", font_addr, exp_fa);
    end
  end

  task automatic wr(input logic [11:0] a, input logic [7:0] c);
    wr_en = 1; wr_addr = a; wr_char = c;
    @(negedge Clk);
    wr_en = 0;
  endtask

  // Present one pixel; font_addr is checked one cycle later, colour two cycles later.
  task automatic px(input int x, input int y, input bit d, input string name,
                    input logic [10:0] efa, input logic [23:0] ergb);
    DrawX = 10'(x); DrawY = 10'(y); de = d;
    @(negedge Clk);
    chk({name, "_fa"}, font_addr, efa);
    @(negedge Clk);
    chk({name, "_rgb"}, {red, green, blue}, ergb);
  endtask

  logic [7:0]  pat;
  logic [10:0] fa;

  initial begin
    foreach (font[i]) font[i] = 8'($urandom);
    font[11'h413] = 8'hA5;
    font[11'h20E] = 8'h00;
    font[11'h20F] = 8'h00;

    // reset, then a reset partway through the clear
    repeat (3) @(negedge Clk);
    chk("reset_rgb", {red, green, blue}, 24'h0);
    chk("reset_font_addr", font_addr, 11'h0);
    chk("reset_busy", busy, 1);
    Reset = 0;
    repeat (1000) @(negedge Clk);
    chk("busy_midclear", busy, 1);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    de = 1;
    for (int k = 1; k <= 2400; k++) begin
      if (k == 100) begin wr_en = 1; wr_addr = 12'd3; wr_char = 8'h55; end
      else wr_en = 0;
      @(negedge Clk);
      if (k == 2399) chk("busy_2399", busy, 1);
      if (k == 2400) chk("busy_fall", busy, 0);
    end
    wr_en = 0;

    // cursor blink at cell (5,2)
    cursor_en = 1; cursor_x = 7'd5; cursor_y = 5'd2;
    px(40, 46, 1, "cursor_on", 11'h20E, FG);
    DrawX = 0; DrawY = 0;
    repeat (32) @(negedge Clk);
    px(40, 47, 1, "cursor_off", 11'h20F, BG);
    DrawX = 0; DrawY = 0;
    repeat (32) @(negedge Clk);
    px(41, 46, 1, "cursor_on2", 11'h20E, FG);
    cursor_en = 0;

    // a write issued during the clear must not have landed
    pat = font[11'h200];
    px(24, 0, 1, "busy_write_drop", 11'h200, pat[7] ? FG : BG);

    // glyph fetch
    wr(12'd0, 8'h41);
    pat = 8'hA5;
    for (int x = 0; x < 8; x++) px(x, 3, 1, "glyph", 11'h413, pat[7 - x] ? FG : BG);
    px(0, 3, 0, "de_low", 11'h413, 24'h0);

    // inverted cell at (1,1)
    wr(12'd81, 8'hC1);
    for (int y = 16; y < 32; y++)
      for (int x = 8; x < 16; x++) begin
        fa  = {7'h41, 4'(y)};
        pat = font[fa];
        px(x, y, 1, "invert", fa, pat[15 - x] ? BG : FG);
      end

    // last cell
    wr(12'd2399, 8'h33);
    pat = font[11'h330];
    px(632, 464, 1, "last_cell", 11'h330, pat[7] ? FG : BG);

    // read/write collision at cell 5, then out-of-range write
    DrawX = 10'd40; DrawY = 10'd0;
    wr_en = 1; wr_addr = 12'd5; wr_char = 8'h42;
    @(negedge Clk);
    wr_en = 0;
    chk("collision_old", font_addr, 11'h200);
    @(negedge Clk);
    chk("collision_new", font_addr, 11'h420);
    wr(12'd2400, 8'h77);

    // random traffic against the model
    repeat (4000) begin
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 479));
      de    = $urandom_range(0, 3) != 0;
      cursor_en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 63) == 0) begin
        cursor_x = 7'($urandom_range(0, 79));
        cursor_y = 5'($urandom_range(0, 29));
      end
      if ($urandom_range(0, 3) == 0) begin
        DrawX = {cursor_x, 3'($urandom_range(0, 7))};
        DrawY = {1'b0, cursor_y, 3'b111, 1'($urandom_range(0, 1))};
      end
      if ($urandom_range(0, 39) == 0) begin DrawX = 0; DrawY = 0; end
      wr_en   = $urandom_range(0, 2) == 0;
      wr_addr = ($urandom_range(0, 2) == 0) ? 12'((DrawY / 16) * 80 + DrawX / 8)
                                            : 12'($urandom_range(0, 2450));
      wr_char = 8'($urandom);
      @(negedge Clk);
    end
    wr_en = 0; de = 0;
    repeat (4) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_tile_renderer.md
# text_tile_renderer

Text-mode pixel generator for the VGA path. Holds an 80x30 character buffer written by the CPU/game side, and reads the 8x16 glyph font ROM (11-bit address = {char[6:0], glyph_row[3:0]}, 8-bit row data, MSB = leftmost pixel). It converts the VGA controller's DrawX/DrawY into a 24-bit RGB pixel with fixed 2-cycle latency, plus a blinking cursor. It sits between the VGA controller and the colour mapper and instantiates the font ROM at the top level.

## Interface
- COLS, 80, text columns
- ROWS, 30, text rows
- FG_RGB, 24'hFFFFFF, foreground colour
- BG_RGB, 24'h000000, background colour
- BLINK_FRAMES, 32, frames per cursor blink phase

- Clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column (0..639)
- DrawY  in  10  current pixel row (0..479)
- de  in  1  display enable, high in visible area
- wr_en  in  1  buffer write strobe
- wr_addr  in  12  cell index, row*COLS+col
- wr_char  in  8  bit7 = invert, bits6:0 = char code
- cursor_en  in  1  cursor visible
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- font_addr  out  11  address to font ROM
- font_data  in  8  font ROM data, combinational from font_addr
- busy  out  1  buffer clear in progress
- red, green, blue  out  8 each  pixel colour

## Operation
- FSM states: CLEAR, RUN. Reset → CLEAR with clr_ptr=0. CLEAR writes 8'h20 (space) to cell clr_ptr and increments it each cycle. At clr_ptr==COLS*ROWS-1 it writes the last cell and moves to RUN. busy=1 exactly while in CLEAR. Reset asserted mid-clear restarts from 0.
- Writes: accepted only in RUN, and only when wr_addr < COLS*ROWS. All others are dropped silently.
- Cell lookup: col = DrawX[9:3], text row = DrawY[8:4], glyph row = DrawY[3:0]. Cell address = row*80+col, computed as (row<<6)+(row<<4)+col in 12 bits.
- Buffer read is synchronous. When a write and a read hit the same address in the same cycle, the read returns the old data.
- font_addr = {cell[6:0], glyph_row}. It is driven from stage-1 registers.
- Pixel bit = font_data[7 - DrawX[2:0]] XOR cell[7].
- Cursor: the cell at (cursor_x, cursor_y) has glyph rows 14 and 15 forced to 1 when cursor_en=1 and blink_phase=1. The forced bit is then XORed with invert.
- Blink counter: advances on a stage-0 frame start (DrawX==0 && DrawY==0). After BLINK_FRAMES frame starts it wraps to 0 and toggles blink_phase. Reset sets counter=0 and blink_phase=1.
- Output colour:
  - de (delayed) = 0 or busy=1 → RGB 0.
  - Pixel bit 1 → FG_RGB.
  - Pixel bit 0 → BG_RGB.

## Timing
- Stage 0 (cycle t): DrawX/DrawY/de drive the buffer read address.
- Stage 1 (cycle t+1): cell data is available. font_addr is valid. glyph_row, DrawX[2:0], de and the cursor-hit flag are carried in registers.
- Stage 2 (cycle t+2): red/green/blue are registered outputs for the pixel presented at t. Latency is exactly 2 cycles in RUN.
- Reset values: red=green=blue=0, font_addr=0, busy=1 on the cycle after Reset, all pipeline de bits=0.
- CLEAR lasts COLS*ROWS cycles. busy falls on cycle 2400 after Reset deasserts. The first write is accepted in the cycle busy is 0.
- A write at cycle t is visible to a read issued at t+1.

## Structure
- Package text_pkg holds:
  - COLS, ROWS, CELLS = 2400, SPACE_CHAR = 8'h20
  - typedef cell_addr_t (logic [11:0])
  - typedef cell_t (packed: invert bit, 7-bit code)
  - FSM state enum {CLEAR, RUN}
- Sub-module text_buffer_ram: one write port and one synchronous-read port, read-before-write, CELLS x 8.
- The font ROM is not instantiated inside this block. font_addr/font_data are ports.

## Test plan
- Reset: pulse Reset 1 cycle → busy=1 for 2400 cycles then 0. RGB=0 throughout. Reading any cell afterwards gives 0x20.
- Glyph fetch: write 0x41 to addr 0, then sweep DrawX=0..7, DrawY=3 with de=1 → font_addr=11'h413 at t+1. RGB at t+2 = FG where font_data bit (7-x) is 1, else BG.
- Invert and addressing:
  - Write 0xC1 to addr 81. Drive DrawX=8..15, DrawY=16..31 → font_addr = {7'h41, DrawY[3:0]}, and pixels are the complement of the non-inverted case.
  - Drive DrawX=632, DrawY=464 → cell 2399 is read.
- Collision and rejects:
  - Write 0x42 to addr 5 while reading addr 5 in the same cycle → old value is used. The next read of addr 5 gives 0x42.
  - A write to addr 2400 is dropped.
  - A write during busy is dropped.
- Cursor: cursor_en=1, (5,2). Cell (5,2) glyph rows 14/15 are all-FG after reset. After 32 frame starts they show font data. After 32 more they are all-FG again.
- Mid-clear reset: assert Reset at clear cycle 1000 → busy stays high a full 2400 cycles after release. de=0 always forces RGB 0.
